// File: rtl/uart_autobaud_pkg.sv
// Shared types for the UART auto-baud block: FSM states and the error codes
// reported on err_code_o.
package uart_autobaud_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_FAST     = 2'b10,
    ERR_MISMATCH = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_WAIT_FALL = 2'b10,
    ST_MEASURE   = 2'b11
  } ab_state_e;

  // A 0x55 character gives 5 falling edges spanning 8 bit-times, so the
  // cycles-per-bit divisor is the total span divided by 8, rounded.
  localparam int unsigned EDGES_PER_CHAR = 5;
  localparam int unsigned SPAN_SHIFT     = 3;
  localparam int unsigned ROUND_BIAS     = 4;
  // Interval tolerance is +/- I1/4.
  localparam int unsigned TOL_SHIFT      = 2;

endpackage

// File: rtl/uart_autobaud_if.sv
// Control/status bundle of the auto-baud block. The slave side is the
// measurement engine; the master side is whoever arms it and consumes div_o.
interface uart_autobaud_if #(
  parameter int DIV_WIDTH = 16
);
  import uart_autobaud_pkg::*;

  logic                 start_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  err_code_e            err_code_o;
  logic [DIV_WIDTH-1:0] div_o;

  modport master (
    output start_i, abort_i,
    input  busy_o, done_o, err_o, err_code_o, div_o
  );

  modport slave (
    input  start_i, abort_i,
    output busy_o, done_o, err_o, err_code_o, div_o
  );

endinterface

// File: rtl/uart_rx_edge_det.sv
// RX line conditioning: synchronizer, optional 3-sample majority filter
// (enabled by UART_AUTOBAUD_GLITCH_FILTER_EN, adds 2 cycles of latency),
// and a falling-edge detector on the conditioned line. All flops reset to 1
// so the idle-high line never produces a spurious edge out of reset.
module uart_rx_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic line_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_prev_q;
  logic                   line_w;

  // Metastability synchronizer chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       maj_w;

  assign maj_w = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                 (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);

  // Majority vote over the last three synchronized samples, registered so a
  // clean step is delayed by a constant 2 cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
      filt_q <= maj_w;
    end
  end

  assign line_w = filt_q;
`else
  assign line_w = sync_q[SYNC_STAGES-1];
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_prev_q <= 1'b1;
    end else begin
      line_prev_q <= line_w;
    end
  end

  assign line_o = line_w;
  assign fall_o = line_prev_q & ~line_w;

endmodule

// File: rtl/uart_autobaud.sv
// UART auto-baud detector. Times the five falling edges of a received 0x55
// and reports the rounded cycles-per-bit divisor. Optional input glitch
// filter: define UART_AUTOBAUD_GLITCH_FILTER_EN.
//
// state        | meaning
// ST_IDLE      | not armed; start_i arms and clears err_code_o
// ST_WAIT_HIGH | armed, waiting for an idle (high) line
// ST_WAIT_FALL | waiting for the start-bit falling edge, no timeout
// ST_MEASURE   | timing edges 2..5, checking interval consistency
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_MIN     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rx_i,
  uart_autobaud_if.slave  bus_if
);

  localparam int IW = DIV_WIDTH + 2;
  localparam int TW = DIV_WIDTH + 4;

  localparam logic [IW-1:0] IVL_SAT   = '1;
  localparam logic [TW:0]   DIV_MAX   = {{(TW+1-DIV_WIDTH){1'b0}}, {DIV_WIDTH{1'b1}}};
  localparam logic [TW:0]   DIV_MIN_T = (TW+1)'(DIV_MIN);
  localparam logic [TW:0]   RND_T     = (TW+1)'(ROUND_BIAS);
  localparam logic [2:0]    LAST_IDX  = 3'(EDGES_PER_CHAR - 2);

  logic line_w;
  logic fall_w;

  uart_rx_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rx_i   (rx_i),
    .line_o (line_w),
    .fall_o (fall_w)
  );

  ab_state_e            state_q, state_d;
  logic [IW-1:0]        ivl_q, ivl_d;
  logic [TW-1:0]        tot_q, tot_d;
  logic [IW-1:0]        i1_q, i1_d;
  logic [2:0]           edge_cnt_q, edge_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  // The interval/total values on an edge cycle include that cycle itself,
  // so an edge N cycles after the previous one measures exactly N.
  logic [IW-1:0] ivl_inc;
  logic [TW-1:0] tot_inc;
  logic [IW:0]   tol_lo, tol_hi;
  logic          in_tol;
  logic [TW:0]   div_full;

  assign ivl_inc  = ivl_q + 1'b1;
  assign tot_inc  = tot_q + 1'b1;
  assign tol_lo   = {1'b0, i1_q} - {1'b0, (i1_q >> TOL_SHIFT)};
  assign tol_hi   = {1'b0, i1_q} + {1'b0, (i1_q >> TOL_SHIFT)};
  assign in_tol   = ({1'b0, ivl_inc} >= tol_lo) && ({1'b0, ivl_inc} <= tol_hi);
  assign div_full = ({1'b0, tot_inc} + RND_T) >> SPAN_SHIFT;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ivl_q      <= '0;
      tot_q      <= '0;
      i1_q       <= '0;
      edge_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      div_q      <= DIV_WIDTH'(DIV_MIN);
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      tot_q      <= tot_d;
      i1_q       <= i1_d;
      edge_cnt_q <= edge_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      div_q      <= div_d;
    end
  end

  // Next-state, counter and result logic. Abort outranks everything, then
  // counter saturation, then the edge checks.
  always_comb begin
    state_d    = state_q;
    ivl_d      = ivl_q;
    tot_d      = tot_q;
    i1_d       = i1_q;
    edge_cnt_d = edge_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    div_d      = div_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.start_i) begin
          state_d    = ST_WAIT_HIGH;
          err_code_d = ERR_NONE;
        end
      end

      ST_WAIT_HIGH: begin
        if (bus_if.abort_i) begin
          state_d = ST_IDLE;
        end else if (line_w) begin
          state_d = ST_WAIT_FALL;
        end
      end

      ST_WAIT_FALL: begin
        if (bus_if.abort_i) begin
          state_d = ST_IDLE;
        end else if (fall_w) begin
          state_d    = ST_MEASURE;
          ivl_d      = '0;
          tot_d      = '0;
          edge_cnt_d = '0;
        end
      end

      ST_MEASURE: begin
        ivl_d = ivl_inc;
        tot_d = tot_inc;
        if (bus_if.abort_i) begin
          state_d = ST_IDLE;
        end else if (ivl_q == IVL_SAT) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (fall_w) begin
          ivl_d      = '0;
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (edge_cnt_q == 3'd0) begin
            i1_d = ivl_inc;
          end else if (!in_tol) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_MISMATCH;
          end else if (edge_cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            if (div_full > DIV_MAX) begin
              err_d      = 1'b1;
              err_code_d = ERR_TIMEOUT;
            end else if (div_full < DIV_MIN_T) begin
              err_d      = 1'b1;
              err_code_d = ERR_FAST;
            end else begin
              done_d = 1'b1;
              div_d  = div_full[DIV_WIDTH-1:0];
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.busy_o     = (state_q != ST_IDLE);
  assign bus_if.done_o     = done_q;
  assign bus_if.err_o      = err_q;
  assign bus_if.err_code_o = err_code_q;
  assign bus_if.div_o      = div_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: two instances (DIV_WIDTH 16 and 8) driven with
// edge-interval patterns, checked against an arithmetic model of the rules.
module tb_uart_autobaud;
  import uart_autobaud_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rx16, rx8;

  uart_autobaud_if #(.DIV_WIDTH(16)) if16 ();
  uart_autobaud_if #(.DIV_WIDTH(8))  if8  ();

  uart_autobaud #(.DIV_WIDTH(16), .DIV_MIN(4), .SYNC_STAGES(2)) dut (
    .clk_i (clk), .rst_i (rst), .rx_i (rx16), .bus_if (if16)
  );

  uart_autobaud #(.DIV_WIDTH(8), .DIV_MIN(4), .SYNC_STAGES(2)) dut8 (
    .clk_i (clk), .rst_i (rst), .rx_i (rx8), .bus_if (if8)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_div16 = 4;
  int exp_div8  = 4;

  // Pulse bookkeeping (counts only; comparisons happen in the test tasks).
  int done16 = 0, err16 = 0, done8 = 0, err8 = 0;
  int busy_at_pulse = 0;
  int div_glitch = 0;
  logic [15:0] div16_prev = 16'd4;
  logic [7:0]  div8_prev  = 8'd4;
  logic        rst_prev   = 1'b1;

  always @(negedge clk) begin
    if (if16.done_o) done16++;
    if (if16.err_o)  err16++;
    if (if8.done_o)  done8++;
    if (if8.err_o)   err8++;
    if ((if16.done_o || if16.err_o) && if16.busy_o) busy_at_pulse++;
    if ((if8.done_o || if8.err_o) && if8.busy_o) busy_at_pulse++;
    if (!rst && !rst_prev) begin
      if (if16.div_o !== div16_prev && !if16.done_o) div_glitch++;
      if (if8.div_o !== div8_prev && !if8.done_o) div_glitch++;
    end
    div16_prev = if16.div_o;
    div8_prev  = if8.div_o;
    rst_prev   = rst;
  end

  typedef struct {
    bit         done;
    logic [1:0] code;
    int         div;
  } res_t;

  // Outcome of one 0x55 measurement from its four fall-to-fall intervals.
  function automatic res_t model(input int iv[4], input int w);
    res_t r;
    int i1, tol, total, d;
    r.done = 1'b0; r.code = 2'b00; r.div = 0;
    i1 = 0; tol = 0; total = 0;
    for (int k = 0; k < 4; k++) begin
      if (iv[k] >= (1 << (w + 2))) begin r.code = 2'b01; return r; end
      if (k == 0) begin
        i1 = iv[0]; tol = i1 / 4;
      end else if (iv[k] < i1 - tol || iv[k] > i1 + tol) begin
        r.code = 2'b11; return r;
      end
      total += iv[k];
    end
    d = (total + 4) / 8;
    if (d > (1 << w) - 1)  r.code = 2'b01;
    else if (d < 4)        r.code = 2'b10;
    else begin r.done = 1'b1; r.div = d; end
    return r;
  endfunction

  task automatic set_rx(input bit sel8, input logic v);
    if (sel8) rx8 = v; else rx16 = v;
  endtask

  task automatic arm(input bit sel8);
    @(negedge clk);
    if (sel8) if8.start_i = 1'b1; else if16.start_i = 1'b1;
    @(negedge clk);
    if8.start_i = 1'b0; if16.start_i = 1'b0;
  endtask

  // Arms the selected instance and produces five falls with the given spacing.
  task automatic drive_char(input bit sel8, input int iv[4]);
    arm(sel8);
    repeat (4) @(negedge clk);
    set_rx(sel8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (iv[k] / 2) @(negedge clk);
      set_rx(sel8, 1'b1);
      repeat (iv[k] - iv[k] / 2) @(negedge clk);
      set_rx(sel8, 1'b0);
    end
    repeat (3) @(negedge clk);
    set_rx(sel8, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx16 = 1'b1; rx8 = 1'b1;
    if16.start_i = 1'b0; if16.abort_i = 1'b0;
    if8.start_i = 1'b0;  if8.abort_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if16.busy_o, if16.done_o, if16.err_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags16: got %b want 000", {if16.busy_o, if16.done_o, if16.err_o});
    end
    n_vec++;
    if (if16.err_code_o !== 2'b00) begin
      n_err++; $display("FAIL reset_code16: got %b want 00", if16.err_code_o);
    end
    n_vec++;
    if (if16.div_o !== 16'd4) begin
      n_err++; $display("FAIL reset_div16: got %0d want 4", if16.div_o);
    end
    n_vec++;
    if ({if8.busy_o, if8.done_o, if8.err_o, if8.err_code_o, if8.div_o} !== {5'b00000, 8'd4}) begin
      n_err++; $display("FAIL reset_dut8: got %b_%0d want 00000_4", {if8.busy_o, if8.done_o, if8.err_o, if8.err_code_o}, if8.div_o);
    end
  endtask

  task automatic test_directed();
    int tab [0:9][0:4] = '{
      '{0, 32, 32, 32, 32},   // 0x55 at 16 cycles/bit
      '{0, 27, 27, 27, 27},   // total 108 -> 14
      '{0,  4,  4,  4,  4},   // 2 cycles/bit, too fast
      '{0, 32, 48, 32, 32},   // second interval out of range
      '{0, 40, 50, 30, 50},   // tolerance edges, inclusive
      '{0, 40, 29, 40, 40},   // just below tolerance
      '{0,  7,  7,  7,  7},   // div exactly DIV_MIN
      '{0,  6,  6,  6,  6},   // div DIV_MIN-1
      '{1, 509, 509, 509, 509}, // div 255 fits 8 bits
      '{1, 512, 512, 512, 512}  // div 256 overflows 8 bits
    };
    int iv[4];
    bit sel8;
    res_t exp;
    int d0, e0, gd, ge, gdiv;
    logic [1:0] gcode;
    for (int i = 0; i < 10; i++) begin
      sel8 = tab[i][0][0];
      for (int j = 0; j < 4; j++) iv[j] = tab[i][j+1];
      exp = model(iv, sel8 ? 8 : 16);
      d0 = sel8 ? done8 : done16;
      e0 = sel8 ? err8 : err16;
      drive_char(sel8, iv);
      if (exp.done) begin
        if (sel8) exp_div8 = exp.div; else exp_div16 = exp.div;
      end
      gd    = (sel8 ? done8 : done16) - d0;
      ge    = (sel8 ? err8 : err16) - e0;
      gcode = sel8 ? if8.err_code_o : if16.err_code_o;
      gdiv  = sel8 ? int'(if8.div_o) : int'(if16.div_o);
      n_vec++;
      if (gd !== int'(exp.done) || ge !== int'(!exp.done)) begin
        n_err++; $display("FAIL dir%0d_pulses: got done=%0d err=%0d want done=%0d err=%0d", i, gd, ge, exp.done, !exp.done);
      end
      n_vec++;
      if (gcode !== exp.code) begin
        n_err++; $display("FAIL dir%0d_code: got %b want %b", i, gcode, exp.code);
      end
      n_vec++;
      if (gdiv !== (sel8 ? exp_div8 : exp_div16)) begin
        n_err++; $display("FAIL dir%0d_div: got %0d want %0d", i, gdiv, sel8 ? exp_div8 : exp_div16);
      end
      n_vec++;
      if ((sel8 ? if8.busy_o : if16.busy_o) !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_busy: got 1 want 0", i);
      end
    end
  endtask

  task automatic test_timeout8();
    int iv[4] = '{2000, 2000, 2000, 2000};
    res_t exp;
    int d0, e0, c;
    exp = model(iv, 8);
    d0 = done8; e0 = err8;
    arm(1'b1);
    repeat (4) @(negedge clk);
    rx8 = 1'b0;
    repeat (400) @(negedge clk);
    rx8 = 1'b1;
    c = 0;
    while (err8 == e0 && c < 1500) begin
      @(negedge clk); c++;
    end
    n_vec++;
    if (err8 == e0) begin
      n_err++; $display("FAIL timeout8_wait: got no err pulse within 1500 cycles want one");
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (if8.err_code_o !== exp.code || done8 !== d0) begin
      n_err++; $display("FAIL timeout8_code: got code=%b done=%0d want code=%b done=0", if8.err_code_o, done8 - d0, exp.code);
    end
    n_vec++;
    if (if8.div_o !== 8'(exp_div8)) begin
      n_err++; $display("FAIL timeout8_div: got %0d want %0d", if8.div_o, exp_div8);
    end
  endtask

  task automatic test_abort();
    int d0, e0;
    d0 = done16; e0 = err16;
    rx16 = 1'b0;
    arm(1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (if16.busy_o !== 1'b1) begin
      n_err++; $display("FAIL abort_armed_busy: got %b want 1", if16.busy_o);
    end
    rx16 = 1'b1;
    repeat (6) @(negedge clk);
    rx16 = 1'b0;
    repeat (10) @(negedge clk);
    if16.abort_i = 1'b1;
    @(negedge clk);
    if16.abort_i = 1'b0;
    n_vec++;
    if (if16.busy_o !== 1'b0) begin
      n_err++; $display("FAIL abort_busy: got %b want 0", if16.busy_o);
    end
    rx16 = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (done16 !== d0 || err16 !== e0 || if16.div_o !== 16'(exp_div16) || if16.err_code_o !== 2'b00) begin
      n_err++; $display("FAIL abort_quiet: got done=%0d err=%0d div=%0d code=%b want 0 0 %0d 00", done16 - d0, err16 - e0, if16.div_o, if16.err_code_o, exp_div16);
    end
  endtask

  task automatic test_abort_edge();
    int d0, e0;
    d0 = done16; e0 = err16;
    arm(1'b0);
    repeat (4) @(negedge clk);
    rx16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (16) @(negedge clk);
      rx16 = 1'b1;
      repeat (16) @(negedge clk);
      if (k < 3) rx16 = 1'b0;
    end
    rx16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if16.abort_i = 1'b1;
    @(negedge clk);
    if16.abort_i = 1'b0;
    repeat (3) @(negedge clk);
    rx16 = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (done16 !== d0 || err16 !== e0 || if16.busy_o !== 1'b0 || if16.div_o !== 16'(exp_div16)) begin
      n_err++; $display("FAIL abort_edge: got done=%0d err=%0d busy=%b div=%0d want 0 0 0 %0d", done16 - d0, err16 - e0, if16.busy_o, if16.div_o, exp_div16);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = done16; e0 = err16;
    arm(1'b0);
    repeat (4) @(negedge clk);
    rx16 = 1'b0;
    repeat (10) @(negedge clk);
    rx16 = 1'b1;
    repeat (10) @(negedge clk);
    rx16 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx16 = 1'b1;
    exp_div16 = 4; exp_div8 = 4;
    repeat (6) @(negedge clk);
    n_vec++;
    if (done16 !== d0 || err16 !== e0 || if16.busy_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_quiet: got done=%0d err=%0d busy=%b want 0 0 0", done16 - d0, err16 - e0, if16.busy_o);
    end
    n_vec++;
    if (if16.div_o !== 16'd4 || if16.err_code_o !== 2'b00) begin
      n_err++; $display("FAIL reset_mid_state: got div=%0d code=%b want 4 00", if16.div_o, if16.err_code_o);
    end
  endtask

  task automatic test_random();
    int iv[4];
    int bitw, tol, dev;
    res_t exp;
    int d0, e0;
    for (int n = 0; n < 12; n++) begin
      bitw  = $urandom_range(30, 2);
      iv[0] = 2 * bitw;
      tol   = iv[0] / 4;
      for (int k = 1; k < 4; k++) begin
        dev = int'($urandom_range(2 * (tol + 1), 0)) - (tol + 1);
        if (n % 4 == 3) dev = dev * 2;
        iv[k] = iv[0] + dev;
        if (iv[k] < 4) iv[k] = 4;
      end
      exp = model(iv, 16);
      d0 = done16; e0 = err16;
      drive_char(1'b0, iv);
      if (exp.done) exp_div16 = exp.div;
      n_vec++;
      if ((done16 - d0) !== int'(exp.done) || (err16 - e0) !== int'(!exp.done)) begin
        n_err++; $display("FAIL rnd%0d_pulses: iv=%0d,%0d,%0d,%0d got done=%0d err=%0d want done=%0d", n, iv[0], iv[1], iv[2], iv[3], done16 - d0, err16 - e0, exp.done);
      end
      n_vec++;
      if (if16.err_code_o !== exp.code || if16.div_o !== 16'(exp_div16)) begin
        n_err++; $display("FAIL rnd%0d_result: iv=%0d,%0d,%0d,%0d got code=%b div=%0d want code=%b div=%0d", n, iv[0], iv[1], iv[2], iv[3], if16.err_code_o, if16.div_o, exp.code, exp_div16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout8();
    test_abort();
    test_abort_edge();
    test_reset_mid();
    test_random();
    n_vec++;
    if (busy_at_pulse !== 0) begin
      n_err++; $display("FAIL busy_at_pulse: got %0d want 0", busy_at_pulse);
    end
    n_vec++;
    if (div_glitch !== 0) begin
      n_err++; $display("FAIL div_without_done: got %0d want 0", div_glitch);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
